// File: rtl/adrv9001_rx_burst_sched.sv
// Receive burst scheduler for one ADRV9001 RX channel: drives rx_enable and frames
// the free-running sample stream into fixed-length AXI-Stream bursts.
module adrv9001_rx_burst_sched #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CNT_WIDTH-1:0] start_delay,
  input  logic [CNT_WIDTH-1:0] burst_len,
  input  logic [CNT_WIDTH-1:0] gap_cycles,
  input  logic [15:0]          num_bursts,
  input  logic [15:0]          timeout,
  output logic                 rx_enable,
  input  logic [31:0]          s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic [31:0]          m_axis_tdata,
  output logic                 m_axis_tvalid,
  output logic                 m_axis_tlast,
  input  logic                 m_axis_tready,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          burst_cnt,
  output logic                 timeout_err,
  output logic                 overflow
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DELAY   = 3'd1,
    ARM     = 3'd2,
    CAPTURE = 3'd3,
    GAP     = 3'd4
  } state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] len_q;
  logic [CNT_WIDTH-1:0] gap_q;
  logic [CNT_WIDTH-1:0] wait_cnt;
  logic [CNT_WIDTH-1:0] smp_cnt;
  logic [15:0]          nb_q;
  logic [15:0]          tmo_q;
  logic [15:0]          tmo_cnt;

  logic        capture_c;
  logic        eob_c;
  logic        final_c;
  logic        load_ok_c;
  logic        tmo_hit_c;
  logic        start_ok_c;
  logic [15:0] bcnt_inc_c;

  // Per-cycle decisions; abort takes precedence over any sample or timeout
  always_comb begin
    capture_c  = s_axis_tvalid && !abort && ((state == ARM) || (state == CAPTURE));
    eob_c      = capture_c && (smp_cnt == (len_q - CNT_WIDTH'(1)));
    bcnt_inc_c = burst_cnt + 16'd1;
    final_c    = (nb_q != 16'd0) && (bcnt_inc_c == nb_q);
    load_ok_c  = !m_axis_tvalid || m_axis_tready;
    tmo_hit_c  = (state == ARM) && !s_axis_tvalid && !abort &&
                 (tmo_q != 16'd0) && (tmo_cnt == (tmo_q - 16'd1));
    start_ok_c = start && (state == IDLE);
  end

  // Schedule FSM with its counters and registered control outputs
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      len_q       <= '0;
      gap_q       <= '0;
      wait_cnt    <= '0;
      smp_cnt     <= '0;
      nb_q        <= '0;
      tmo_q       <= '0;
      tmo_cnt     <= '0;
      rx_enable   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      burst_cnt   <= '0;
      timeout_err <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          rx_enable <= 1'b0;
          if (start) begin
            state       <= DELAY;
            busy        <= 1'b1;
            wait_cnt    <= start_delay;
            len_q       <= (burst_len == '0) ? CNT_WIDTH'(1) : burst_len;
            gap_q       <= gap_cycles;
            nb_q        <= num_bursts;
            tmo_q       <= timeout;
            burst_cnt   <= '0;
            timeout_err <= 1'b0;
          end
        end
        DELAY, GAP: begin
          rx_enable <= 1'b0;
          if (wait_cnt == '0) begin
            state   <= ARM;
            smp_cnt <= '0;
            tmo_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt - CNT_WIDTH'(1);
          end
        end
        ARM, CAPTURE: begin
          rx_enable <= 1'b1;
          if (tmo_hit_c) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b1;
            timeout_err <= 1'b1;
            rx_enable   <= 1'b0;
          end else if (capture_c) begin
            state   <= CAPTURE;
            smp_cnt <= smp_cnt + CNT_WIDTH'(1);
            if (eob_c) begin
              burst_cnt <= bcnt_inc_c;
              smp_cnt   <= '0;
              if (final_c) begin
                state     <= IDLE;
                busy      <= 1'b0;
                done      <= 1'b1;
                rx_enable <= 1'b0;
              end else begin
                // A one-sample burst ending straight out of ARM keeps rx_enable for one GAP cycle
                state    <= GAP;
                wait_cnt <= gap_q;
                if (state == CAPTURE) rx_enable <= 1'b0;
              end
            end
          end else if (state == ARM) begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          rx_enable <= 1'b0;
        end
      endcase
      if (abort && (state != IDLE)) begin
        state     <= IDLE;
        busy      <= 1'b0;
        done      <= 1'b1;
        rx_enable <= 1'b0;
      end
    end
  end

  // Single-entry output register; a sample that finds it occupied is dropped and flagged
  always_ff @(posedge clk) begin
    if (!rstn) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      if (start_ok_c) overflow <= 1'b0;
      if (capture_c) begin
        if (load_ok_c) begin
          m_axis_tdata  <= s_axis_tdata;
          m_axis_tlast  <= eob_c;
          m_axis_tvalid <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/adrv9001_rx_burst_sched.md
# adrv9001_rx_burst_sched

Burst scheduler for one ADRV9001 receive channel. Runs in the channel's sample clock domain (the divided SSI clock). It drives the channel's receive enable and gates the channel's sample stream into framed bursts of programmed length on an AXI-Stream master, with `tlast` on the last sample of each burst. Software programs the start delay, burst length, inter-burst gap, burst count and first-sample timeout, then issues `start`.

## Interface
Parameters:
- `CNT_WIDTH`, default 32: width of the `start_delay`, `burst_len` and `gap_cycles` counters.

Ports:
- `clk`, in, 1: sample-domain clock; all logic is on the rising edge.
- `rstn`, in, 1: synchronous, active-low reset.
- `start`, in, 1: one-cycle pulse that starts a schedule; ignored unless the FSM is in IDLE.
- `abort`, in, 1: one-cycle pulse that terminates the schedule from any state.
- `start_delay`, in, CNT_WIDTH: cycles from `start` to first `rx_enable` assertion.
- `burst_len`, in, CNT_WIDTH: samples per burst; 0 is treated as 1.
- `gap_cycles`, in, CNT_WIDTH: cycles from end of one burst to re-enable for the next.
- `num_bursts`, in, 16: bursts per schedule; 0 means run until `abort`.
- `timeout`, in, 16: maximum cycles in ARM without a sample; 0 disables the timeout.
- `rx_enable`, out, 1: receive enable to the RX channel.
- `s_axis_tdata`, in, 32: sample from the RX channel, packed as {I[15:0], Q[15:0]}.
- `s_axis_tvalid`, in, 1: sample valid. There is no ready; the channel cannot stall.
- `m_axis_tdata`, out, 32: burst sample.
- `m_axis_tvalid`, out, 1: output sample valid.
- `m_axis_tlast`, out, 1: asserted with the last sample of each burst.
- `m_axis_tready`, in, 1: downstream ready.
- `busy`, out, 1: high whenever the FSM is not in IDLE.
- `done`, out, 1: one-cycle pulse when the schedule ends.
- `burst_cnt`, out, 16: number of bursts completed in the current schedule.
- `timeout_err`, out, 1: sticky flag; cleared on an accepted `start`.
- `overflow`, out, 1: sticky flag; cleared on an accepted `start`.

## Operation
- **Reset:** state IDLE; every output is 0.
- **Configuration latch:** all configuration inputs are latched on an accepted `start`. Later changes have no effect until the next `start`.
- **States:** IDLE, DELAY, ARM, CAPTURE, GAP.
  - **IDLE → DELAY:** on `start`. The delay counter loads `start_delay`, and `burst_cnt`, `timeout_err` and `overflow` clear.
  - **DELAY → ARM:** when the delay counter is 0, checked each cycle (decrement if nonzero). `start_delay = 0` therefore reaches ARM one cycle after DELAY entry.
  - **ARM:** `rx_enable = 1` and the timeout counter runs.
    - The first `s_axis_tvalid` sample is captured and counted as sample 1, and the FSM moves to CAPTURE.
    - If that sample also ends the burst (effective length 1), the end-of-burst rule applies directly.
    - Timeout: if the counter reaches `timeout` (nonzero) with no sample, set `timeout_err`, pulse `done`, and go to IDLE.
  - **CAPTURE:** `rx_enable = 1`. Each `s_axis_tvalid` sample is forwarded and counted.
  - **End of burst:** on the sample that reaches the effective length:
    - `tlast = 1` on that sample, `burst_cnt` increments, and `rx_enable` drops on the next cycle.
    - If `num_bursts != 0` and the incremented `burst_cnt == num_bursts`: pulse `done` and go to IDLE.
    - Otherwise go to GAP with the counter loaded from `gap_cycles`.
  - **GAP → ARM:** when the gap counter reaches 0 (same rule as DELAY).
- **Discarded samples:** samples arriving in IDLE, DELAY or GAP (the channel's disable-delay tail) are dropped silently and do not set `overflow`.
- **Output register:** single entry.
  - A sample is loaded when the register is empty, or when it is being accepted in the same cycle (`tvalid && tready`).
  - If a sample arrives while the register holds an unaccepted word, the new sample is dropped and `overflow` is set. The dropped sample still counts toward `burst_len`, so burst timing stays locked to the channel. If the dropped sample was the burst's last, `tlast` is lost with it; `overflow` flags this.
- **Abort:** in any non-IDLE state, the FSM goes to IDLE on the next cycle with `rx_enable = 0` and a `done` pulse. A word pending in the output register is held until accepted, per AXI-Stream rules.
- **Abort and start together:** `abort` and `start` in the same cycle while in IDLE: `start` wins and `abort` is ignored.
- **Counter widths:** the sample counter is CNT_WIDTH wide and compares against the effective length; it never wraps within a burst. `burst_cnt` wraps at 2^16 in unlimited mode.

## Timing
- `rx_enable` is registered. It rises on the cycle after ARM entry and falls on the cycle after the last sample of the final or terminating burst.
- Input-to-output latency is 1 cycle: `s_axis_tvalid` at cycle n gives `m_axis_tvalid` at n+1 when the output register is free.
- `done` is a single-cycle pulse, coincident with `busy` falling.
- `start` to `rx_enable` high is `start_delay + 2` cycles.
- With a continuous sample stream, `rx_enable` low time between bursts is `gap_cycles + 2` cycles.

## Test plan
- **Basic schedule:** `start_delay=10`, `burst_len=4`, `gap_cycles=5`, `num_bursts=2`, continuous valid, `tready=1`.
  - Expect two bursts of 4 samples with `tlast` on the 4th and `rx_enable` high 12 cycles after `start`.
  - Expect `burst_cnt=2`, one `done` pulse, and no flags set.
- **Timeout:** `timeout=20` with no input valid. Expect `timeout_err=1` and `done` 20 cycles after ARM entry, `rx_enable` back to 0, and zero output samples.
- **Backpressure:** `tready=0` for 3 cycles mid-burst. Expect `overflow=1`, the held word unchanged until accepted, and burst boundaries still at `burst_len` input samples.
- **Abort:** `num_bursts=0`, abort during the 3rd burst. Expect `rx_enable=0` and a `done` pulse on the next cycle, the pending word still delivered, and `burst_cnt=2`.
- **Edge values:** `burst_len=0` with `start_delay=0`. Expect 1-sample bursts each carrying `tlast`, and `rx_enable` high 2 cycles after `start`.
- **Reset and restart:** `rstn` low mid-CAPTURE. Expect all outputs 0 the cycle after reset. A subsequent `start` clears flags and runs a clean schedule; a `start` while busy is ignored.
